// File: rtl/conv2_stream.sv
// ============================================================================
// Module   : conv2_stream
// Brief    : Streaming KSIZE x KSIZE convolution over a raster pixel stream,
//            with line buffers, shift/saturate/ReLU output stage.
// Revision : 1.0
// ============================================================================
`default_nettype none

module conv2_stream #(
    parameter int IMG_W     = 320,
    parameter int IMG_H     = 320,
    parameter int KSIZE     = 3,
    parameter int WIDTH_BIT = 16,
    parameter int SHIFT     = 0,
    parameter int ACC_W     = 2*WIDTH_BIT + $clog2(KSIZE*KSIZE)
) (
    input  logic                                clock,
    input  logic                                nreset,
    input  logic                                start,
    input  logic                                relu_en,
    input  logic                                ker_we,
    input  logic [$clog2(KSIZE*KSIZE)-1:0]      ker_addr,
    input  logic signed [WIDTH_BIT-1:0]         ker_data,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic signed [WIDTH_BIT-1:0]         in_data,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic signed [WIDTH_BIT-1:0]         out_data,
    output logic                                busy,
    output logic                                done
);

    localparam int C_TAPS  = KSIZE*KSIZE;
    localparam int C_ROW_W = $clog2(IMG_H);
    localparam int C_COL_W = $clog2(IMG_W);
    localparam int C_PROD_W = 2*WIDTH_BIT;

    localparam logic [C_ROW_W-1:0] C_ROW_FIRST = C_ROW_W'(KSIZE-1);
    localparam logic [C_ROW_W-1:0] C_ROW_LAST  = C_ROW_W'(IMG_H-1);
    localparam logic [C_COL_W-1:0] C_COL_FIRST = C_COL_W'(KSIZE-1);
    localparam logic [C_COL_W-1:0] C_COL_LAST  = C_COL_W'(IMG_W-1);

    localparam logic signed [ACC_W-1:0] C_SAT_MAX =
        {{(ACC_W-WIDTH_BIT+1){1'b0}}, {(WIDTH_BIT-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] C_SAT_MIN =
        {{(ACC_W-WIDTH_BIT+1){1'b1}}, {(WIDTH_BIT-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [C_ROW_W-1:0]          r_row;
    logic [C_COL_W-1:0]          r_col;
    logic                        r_relu;
    logic                        r_out_valid;
    logic signed [WIDTH_BIT-1:0] r_out_data;
    logic                        r_done;

    logic signed [WIDTH_BIT-1:0] r_ker  [C_TAPS];
    logic signed [WIDTH_BIT-1:0] r_line [KSIZE-1][IMG_W];
    logic signed [WIDTH_BIT-1:0] r_win  [KSIZE][KSIZE];

    logic signed [WIDTH_BIT-1:0] w_col      [KSIZE];
    logic signed [WIDTH_BIT-1:0] w_win_next [KSIZE][KSIZE];
    logic signed [C_PROD_W-1:0]  w_prod     [KSIZE][KSIZE];
    logic signed [ACC_W-1:0]     w_acc;
    logic signed [ACC_W-1:0]     w_shift;
    logic signed [WIDTH_BIT-1:0] w_sat;
    logic signed [WIDTH_BIT-1:0] w_res;

    logic w_accept;
    logic w_last_pix;
    logic w_win_done;
    logic w_out_hs;
    logic w_done_set;

    assign in_ready   = (r_state == S_RUN) && (!r_out_valid || out_ready);
    assign w_accept   = in_valid && in_ready;
    assign w_last_pix = (r_row == C_ROW_LAST) && (r_col == C_COL_LAST);
    assign w_win_done = (r_row >= C_ROW_FIRST) && (r_col >= C_COL_FIRST);
    assign w_out_hs   = r_out_valid && out_ready;

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign busy      = (r_state != S_IDLE);
    assign done      = r_done;

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_done_set   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (w_accept && w_last_pix) begin
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_out_hs) begin
                    w_state_next = S_IDLE;
                    w_done_set   = 1'b1;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            r_row  <= '0;
            r_col  <= '0;
            r_relu <= 1'b0;
        end else if ((r_state == S_IDLE) && start) begin
            r_row  <= '0;
            r_col  <= '0;
            r_relu <= relu_en;
        end else if (w_accept) begin
            if (r_col == C_COL_LAST) begin
                r_col <= '0;
                r_row <= r_row + C_ROW_W'(1);
            end else begin
                r_col <= r_col + C_COL_W'(1);
            end
        end
    end

    // Coefficients are frozen for the whole frame once the engine leaves IDLE.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            for (int t = 0; t < C_TAPS; t++) begin
                r_ker[t] <= '0;
            end
        end else if ((r_state == S_IDLE) && ker_we && (int'(ker_addr) < C_TAPS)) begin
            r_ker[ker_addr] <= ker_data;
        end
    end

    // Row KSIZE-1 of the window is the live pixel; row KSIZE-2-k comes from line k.
    for (genvar gi = 0; gi < KSIZE; gi++) begin : g_row
        if (gi == KSIZE-1) begin : g_new
            assign w_col[gi] = in_data;
        end else begin : g_line
            assign w_col[gi] = r_line[KSIZE-2-gi][r_col];
        end
        for (genvar gj = 0; gj < KSIZE; gj++) begin : g_tap
            if (gj == KSIZE-1) begin : g_load
                assign w_win_next[gi][gj] = w_col[gi];
            end else begin : g_shift
                assign w_win_next[gi][gj] = r_win[gi][gj+1];
            end
            assign w_prod[gi][gj] = C_PROD_W'(w_win_next[gi][gj]) * C_PROD_W'(r_ker[gi*KSIZE+gj]);
        end
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            for (int k = 0; k < KSIZE-1; k++) begin
                for (int c = 0; c < IMG_W; c++) begin
                    r_line[k][c] <= '0;
                end
            end
            for (int i = 0; i < KSIZE; i++) begin
                for (int j = 0; j < KSIZE; j++) begin
                    r_win[i][j] <= '0;
                end
            end
        end else if (w_accept) begin
            r_line[0][r_col] <= in_data;
            for (int k = 1; k < KSIZE-1; k++) begin
                r_line[k][r_col] <= r_line[k-1][r_col];
            end
            for (int i = 0; i < KSIZE; i++) begin
                for (int j = 0; j < KSIZE; j++) begin
                    r_win[i][j] <= w_win_next[i][j];
                end
            end
        end
    end

    always_comb begin
        w_acc = '0;
        for (int i = 0; i < KSIZE; i++) begin
            for (int j = 0; j < KSIZE; j++) begin
                w_acc = w_acc + ACC_W'(w_prod[i][j]);
            end
        end
    end

    assign w_shift = w_acc >>> SHIFT;

    always_comb begin
        w_sat = w_shift[WIDTH_BIT-1:0];
        if (w_shift > C_SAT_MAX) begin
            w_sat = C_SAT_MAX[WIDTH_BIT-1:0];
        end else if (w_shift < C_SAT_MIN) begin
            w_sat = C_SAT_MIN[WIDTH_BIT-1:0];
        end
    end

    assign w_res = (r_relu && w_sat[WIDTH_BIT-1]) ? '0 : w_sat;

    // A new result may overwrite the current one only when it is being consumed.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else if (w_accept && w_win_done) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_res;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            r_done <= 1'b0;
        end else begin
            r_done <= w_done_set;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_conv2_stream.sv
// ============================================================================
// Module   : tb_conv2_stream
// Brief    : Self-checking bench for conv2_stream (5x5 image, 3x3 kernel).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_conv2_stream;

    localparam int IW = 5;
    localparam int IH = 5;
    localparam int K  = 3;
    localparam int NOUT = (IH-K+1)*(IW-K+1);

    logic clock = 1'b0;
    logic nreset = 1'b0;
    logic start = 1'b0;
    logic relu_en = 1'b0;
    logic ker_we = 1'b0;
    logic [3:0] ker_addr = '0;
    logic signed [15:0] ker_data = '0;
    logic in_valid = 1'b0;
    logic signed [15:0] in_data = '0;
    logic out_ready = 1'b1;

    logic in_ready0, out_valid0, busy0, done0;
    logic signed [15:0] out_data0;
    logic in_ready1, out_valid1, busy1, done1;
    logic signed [15:0] out_data1;

    always #5 clock = ~clock;

    conv2_stream #(.IMG_W(IW), .IMG_H(IH), .KSIZE(K), .WIDTH_BIT(16), .SHIFT(0)) u_dut (
        .clock(clock), .nreset(nreset), .start(start), .relu_en(relu_en),
        .ker_we(ker_we), .ker_addr(ker_addr), .ker_data(ker_data),
        .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
        .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
        .busy(busy0), .done(done0)
    );

    conv2_stream #(.IMG_W(IW), .IMG_H(IH), .KSIZE(K), .WIDTH_BIT(16), .SHIFT(2)) u_dut_sh (
        .clock(clock), .nreset(nreset), .start(start), .relu_en(relu_en),
        .ker_we(ker_we), .ker_addr(ker_addr), .ker_data(ker_data),
        .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
        .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
        .busy(busy1), .done(done1)
    );

    int kern [K*K];
    int img  [IH][IW];
    int exp0 [$];
    int exp1 [$];
    int cap0 [$];
    int cap1 [$];
    int total = 0;
    int bad = 0;
    int done_seen = 0;
    bit rand_ready = 1'b0;

    task automatic check(input string name, input int act, input int expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    // Reference: direct sum over the window, floor shift, clamp, optional ReLU.
    function automatic int model_out(input int r0, input int c0, input int sh, input bit relu);
        longint acc = 0;
        for (int i = 0; i < K; i++)
            for (int j = 0; j < K; j++)
                acc += longint'(kern[i*K+j]) * longint'(img[r0+i][c0+j]);
        acc = acc >>> sh;
        if (acc > 32767) acc = 32767;
        if (acc < -32768) acc = -32768;
        if (relu && acc < 0) acc = 0;
        return int'(acc);
    endfunction

    function automatic int cap_at(input int which, input int idx);
        if (which == 0) return (idx < cap0.size()) ? cap0[idx] : 99999;
        return (idx < cap1.size()) ? cap1[idx] : 99999;
    endfunction

    always begin
        @(posedge clock);
        #1;
        out_ready = rand_ready ? ($urandom_range(0, 99) < 30) : 1'b1;
    end

    logic prev_stall0 = 1'b0, prev_stall1 = 1'b0, prev_done = 1'b0;
    int prev_d0 = 0, prev_d1 = 0;

    always @(negedge clock) begin
        if (!nreset) begin
            prev_stall0 = 1'b0;
            prev_stall1 = 1'b0;
            prev_done = 1'b0;
        end else begin
            if (prev_stall0) check("hold0", int'(out_data0), prev_d0);
            if (prev_stall1) check("hold1", int'(out_data1), prev_d1);
            if (out_valid0 && !out_ready) check("bp_in_ready", int'(in_ready0), 0);
            if (out_valid0 && out_ready) begin
                if (exp0.size() == 0) check("extra_out0", 1, 0);
                else check("model0", int'(out_data0), exp0.pop_front());
                cap0.push_back(int'(out_data0));
            end
            if (out_valid1 && out_ready) begin
                if (exp1.size() == 0) check("extra_out1", 1, 0);
                else check("model1", int'(out_data1), exp1.pop_front());
                cap1.push_back(int'(out_data1));
            end
            if (done0) begin
                check("done_one_cycle", int'(prev_done), 0);
                check("busy_at_done", int'(busy0), 0);
                done_seen++;
            end
            prev_done = done0;
            prev_stall0 = out_valid0 && !out_ready;
            prev_stall1 = out_valid1 && !out_ready;
            prev_d0 = int'(out_data0);
            prev_d1 = int'(out_data1);
        end
    end

    task automatic write_kernel();
        for (int t = 0; t < K*K; t++) begin
            ker_we = 1'b1;
            ker_addr = 4'(t);
            ker_data = 16'(kern[t]);
            @(posedge clock);
            #1;
        end
        ker_we = 1'b0;
    endtask

    task automatic fill_img(input int v);
        for (int r = 0; r < IH; r++)
            for (int c = 0; c < IW; c++)
                img[r][c] = v;
    endtask

    task automatic run_frame(input bit relu, input bit gaps, input int abort_at,
                             input bit check_stall, input bit ker_poke);
        int stalls = 0;
        int guard;
        bit timed_out = 1'b0;
        cap0.delete(); cap1.delete(); exp0.delete(); exp1.delete();
        for (int r0 = 0; r0 <= IH-K; r0++)
            for (int c0 = 0; c0 <= IW-K; c0++) begin
                exp0.push_back(model_out(r0, c0, 0, relu));
                exp1.push_back(model_out(r0, c0, 2, relu));
            end
        start = 1'b1;
        relu_en = relu;
        @(posedge clock);
        #1;
        start = 1'b0;
        relu_en = 1'b0;
        for (int p = 0; p < IH*IW && !timed_out; p++) begin
            if (p == abort_at) begin
                in_valid = 1'b0;
                nreset = 1'b0;
                #2;
                check("abort_out_valid", int'(out_valid0), 0);
                check("abort_out_data", int'(out_data0), 0);
                check("abort_in_ready", int'(in_ready0), 0);
                check("abort_busy", int'(busy0), 0);
                check("abort_done", int'(done0), 0);
                exp0.delete(); exp1.delete();
                for (int t = 0; t < K*K; t++) kern[t] = 0;
                guard = done_seen;
                repeat (2) @(posedge clock);
                #1;
                nreset = 1'b1;
                repeat (20) @(negedge clock);
                check("no_done_after_abort", done_seen - guard, 0);
                return;
            end
            in_data = 16'(img[p / IW][p % IW]);
            in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (ker_poke && p == 3) begin
                ker_we = 1'b1;
                ker_addr = 4'd4;
                ker_data = 16'sd5;
            end
            guard = 0;
            forever begin
                @(negedge clock);
                if (in_valid && in_ready0) begin
                    @(posedge clock);
                    #1;
                    break;
                end
                if (check_stall && !in_ready0) stalls++;
                guard++;
                if (guard > 500) begin
                    check("in_accept_timeout", guard, 0);
                    timed_out = 1'b1;
                    break;
                end
                @(posedge clock);
                #1;
                if (gaps) in_valid = ($urandom_range(0, 3) != 0);
            end
            ker_we = 1'b0;
        end
        in_valid = 1'b0;
        ker_we = 1'b0;
        if (check_stall) check("in_ready_every_run_cycle", stalls, 0);
        guard = 0;
        do begin
            @(negedge clock);
            guard++;
        end while (!done0 && guard < 1000);
        check("done_seen", int'(done0), 1);
        check("output_count", cap0.size(), NOUT);
        check("model_queue_empty", exp0.size(), 0);
    endtask

    int ident [NOUT] = '{6, 7, 8, 11, 12, 13, 16, 17, 18};

    initial begin
        #12;
        check("rst_out_valid", int'(out_valid0), 0);
        check("rst_out_data", int'(out_data0), 0);
        check("rst_in_ready", int'(in_ready0), 0);
        check("rst_busy", int'(busy0), 0);
        check("rst_done", int'(done0), 0);
        @(posedge clock);
        #1;
        nreset = 1'b1;

        // All ones
        for (int t = 0; t < K*K; t++) kern[t] = 1;
        write_kernel();
        fill_img(1);
        run_frame(1'b0, 1'b0, -1, 1'b1, 1'b0);
        for (int i = 0; i < NOUT; i++) check("ones_literal", cap_at(0, i), 9);

        // Identity kernel on ramp image
        for (int t = 0; t < K*K; t++) kern[t] = (t == 4) ? 1 : 0;
        write_kernel();
        for (int r = 0; r < IH; r++)
            for (int c = 0; c < IW; c++)
                img[r][c] = r*IW + c;
        run_frame(1'b0, 1'b0, -1, 1'b0, 1'b0);
        for (int i = 0; i < NOUT; i++) check("ident_literal", cap_at(0, i), ident[i]);

        // Saturation; frames launched back to back on the done cycle
        for (int t = 0; t < K*K; t++) kern[t] = 1;
        write_kernel();
        fill_img(32767);
        run_frame(1'b0, 1'b0, -1, 1'b0, 1'b0);
        check("sat_pos_literal", cap_at(0, 0), 32767);
        fill_img(-32768);
        run_frame(1'b0, 1'b0, -1, 1'b0, 1'b0);
        check("sat_neg_literal", cap_at(0, 4), -32768);
        run_frame(1'b1, 1'b0, -1, 1'b0, 1'b0);
        check("relu_literal", cap_at(0, 8), 0);

        // Shifted instance
        fill_img(3);
        run_frame(1'b0, 1'b0, -1, 1'b0, 1'b0);
        check("shift_pos_literal", cap_at(1, 0), 6);
        check("noshift_literal", cap_at(0, 0), 27);
        fill_img(-3);
        run_frame(1'b0, 1'b0, -1, 1'b0, 1'b0);
        check("shift_neg_literal", cap_at(1, 3), -7);

        // Random data, random backpressure, input gaps
        for (int t = 0; t < K*K; t++) kern[t] = $urandom_range(0, 16) - 8;
        write_kernel();
        for (int r = 0; r < IH; r++)
            for (int c = 0; c < IW; c++)
                img[r][c] = $urandom_range(0, 600) - 300;
        rand_ready = 1'b1;
        run_frame(1'b0, 1'b1, -1, 1'b0, 1'b0);
        run_frame(1'b1, 1'b1, -1, 1'b0, 1'b0);
        rand_ready = 1'b0;
        repeat (2) @(posedge clock);
        #1;

        // Abort mid-frame, then kernel is back to zero
        for (int t = 0; t < K*K; t++) kern[t] = 1;
        write_kernel();
        fill_img(2);
        run_frame(1'b0, 1'b0, 14, 1'b0, 1'b0);
        run_frame(1'b0, 1'b0, -1, 1'b0, 1'b0);
        check("zero_kernel_literal", cap_at(0, 0), 0);

        // Kernel write during RUN is ignored
        for (int t = 0; t < K*K; t++) kern[t] = (t == 4) ? 1 : 0;
        write_kernel();
        for (int r = 0; r < IH; r++)
            for (int c = 0; c < IW; c++)
                img[r][c] = r*IW + c;
        run_frame(1'b0, 1'b0, -1, 1'b0, 1'b1);
        for (int i = 0; i < NOUT; i++) check("poke_frame_literal", cap_at(0, i), ident[i]);
        run_frame(1'b0, 1'b0, -1, 1'b0, 1'b0);
        for (int i = 0; i < NOUT; i++) check("after_poke_literal", cap_at(0, i), ident[i]);

        repeat (3) @(posedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/conv2_stream.md
# conv2_stream

Streaming 2D convolution engine, parametrised successor to the frame-buffered `conv2`. An IMG_H x IMG_W image enters one pixel per beat in raster order over a valid/ready handshake. The engine convolves it with a runtime-loadable KSIZE x KSIZE kernel using KSIZE-1 line buffers, and streams out the valid region of the result, also in raster order.

Each output is scaled by a fixed-point right shift, saturated to WIDTH_BIT, and optionally passed through ReLU. It sits between the pixel source and the next network layer, and replaces whole-matrix ports.

## Interface

Parameters:
- IMG_W, default 320: image width in pixels.
- IMG_H, default 320: image height in pixels.
- KSIZE, default 3: kernel side length. Must satisfy 2 ≤ KSIZE ≤ min(IMG_W, IMG_H).
- WIDTH_BIT, default 16: signed pixel, kernel and output width.
- SHIFT, default 0: arithmetic right shift applied to the accumulator before saturation.
- ACC_W, default 2*WIDTH_BIT+$clog2(KSIZE*KSIZE): accumulator width.

Ports:
- clock  in  1  rising-edge clock.
- nreset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a frame when the engine is in IDLE.
- relu_en  in  1  sampled at start; when 1, negative results become 0.
- ker_we  in  1  kernel coefficient write enable.
- ker_addr  in  $clog2(KSIZE*KSIZE)  coefficient index, row-major: index = i*KSIZE+j.
- ker_data  in  WIDTH_BIT  signed coefficient.
- in_valid  in  1  input pixel valid.
- in_ready  out  1  engine accepts a pixel this cycle.
- in_data  in  WIDTH_BIT  signed pixel.
- out_valid  out  1  output result valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  WIDTH_BIT  signed result.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  one-cycle pulse after the last result is accepted.

## Operation

- FSM states:
  - IDLE: start → RUN. Row and column counters clear; relu_en is latched.
  - RUN: pixels are accepted. When the last pixel (IMG_H-1, IMG_W-1) is accepted → DRAIN.
  - DRAIN: the last result is accepted (out_valid && out_ready) → IDLE and done=1.
- Handshakes:
  - in_ready = (state==RUN) && (!out_valid || out_ready).
  - A pixel is accepted when in_valid && in_ready.
  - The column counter wraps IMG_W-1→0 and then increments the row counter.
- Line buffers: KSIZE-1 rows of IMG_W entries plus a KSIZE x KSIZE window shift register. They advance only on an accepted pixel.
- Result production:
  - An accepted pixel at (r,c) with r ≥ KSIZE-1 and c ≥ KSIZE-1 completes the window with top-left corner (r-KSIZE+1, c-KSIZE+1).
  - Its result is registered into out_data with out_valid=1.
  - Other accepted pixels produce no output.
  - Total outputs per frame: (IMG_H-KSIZE+1)*(IMG_W-KSIZE+1).
- Arithmetic:
  - acc = Σ ker[i][j]*win[i][j], computed signed at full ACC_W precision with no intermediate truncation.
  - Then apply acc >>> SHIFT (floor).
  - Then saturate to [-2^(WIDTH_BIT-1), 2^(WIDTH_BIT-1)-1].
  - Then, if the latched relu_en=1, clamp negative results to 0.
- Kernel memory:
  - A write with ker_we=1 in IDLE updates the coefficient at the next edge.
  - ker_we is ignored in RUN and DRAIN.
- start outside IDLE is ignored.
- in_valid while not in RUN is ignored; no pixel is consumed.

## Timing

- Reset (async assert, synchronous release) clears:
  - state=IDLE; all counters to 0;
  - out_valid=0, out_data=0, in_ready=0, busy=0, done=0;
  - all kernel coefficients = 0; line buffers = 0.
- Reset asserted mid-frame aborts the frame and does not pulse done.
- Latency: a window-completing pixel accepted at edge N gives out_valid=1 after edge N.
- Backpressure:
  - While out_valid && !out_ready, out_data holds stable and in_ready=0.
  - Simultaneous out_ready=1 and a new accepted pixel replaces the result in the same cycle, giving full throughput of 1 pixel/cycle.
- start sampled at edge N gives busy=1 and in_ready=1 from edge N.
- done is high for exactly one cycle, the cycle after the final output handshake; busy=0 in that same cycle.
- Back-to-back frames: a start on the cycle done=1 is accepted.

## Test plan

- IMG_W=IMG_H=5, KSIZE=3, SHIFT=0, all coefficients 1, all pixels 1, out_ready=1 → exactly 9 outputs of 9, then done; in_ready high on every RUN cycle.
- Identity kernel (coefficient 4 = 1, others 0), pixel value = r*5+c → outputs 6,7,8,11,12,13,16,17,18 in order.
- Saturation, all coefficients 1:
  - pixels 0x7FFF → every output 0x7FFF;
  - pixels 0x8000 → 0x8000;
  - pixels 0x8000 with relu_en=1 → 0x0000.
- SHIFT=2, all coefficients 1, pixels 3 (acc=27) → outputs 6; pixels -3 → -7.
- Random out_ready at 30% duty with in_valid gaps → output sequence identical to the golden model; out_data is stable while stalled; no pixel lost.
- Reset pulse mid-frame → all outputs at reset values, no done. A kernel write attempted in RUN is ignored: the next frame uses the old coefficient.
